// File: rtl/mem_req_arbiter_pkg.sv
// Shared header: grant FSM encoding and sram-like transfer size encodings.
package mem_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOLD_INST = 2'd1,
    ST_HOLD_DATA = 2'd2
  } grant_state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } sram_size_t;

  localparam logic TAG_INST = 1'b0;
  localparam logic TAG_DATA = 1'b1;

endpackage

// File: rtl/mem_req_arbiter_tag_fifo.sv
// Source-tag FIFO: remembers which side issued each accepted request so that
// in-order responses can be routed back.
module tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-master (inst/data) to one-slave sram-like arbiter with fixed data
// priority, grant holding across stalls and in-order response routing.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  grant_state_t r_state;
  logic         w_sel_data;
  logic         w_sel_req;
  logic         w_hs;
  logic         w_pop;
  logic         w_head_tag;
  logic         w_fifo_full;
  logic         w_fifo_empty;

  always_comb begin
    w_sel_data = 1'b0;
    case (r_state)
      ST_IDLE:      w_sel_data = data_req;
      ST_HOLD_DATA: w_sel_data = 1'b1;
      ST_HOLD_INST: w_sel_data = 1'b0;
      default:      w_sel_data = 1'b0;
    endcase
  end

  always_comb begin
    w_sel_req = inst_req;
    mem_wr    = inst_wr;
    mem_size  = inst_size;
    mem_addr  = inst_addr;
    mem_wdata = inst_wdata;
    if (w_sel_data) begin
      w_sel_req = data_req;
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  // A full tag FIFO blocks issue even when a pop frees a slot this cycle.
  assign mem_req      = w_sel_req & ~w_fifo_full;
  assign w_hs         = mem_req & mem_addr_ok;
  assign inst_addr_ok = w_hs & ~w_sel_data;
  assign data_addr_ok = w_hs & w_sel_data;

  assign w_pop        = mem_data_ok & ~w_fifo_empty;
  assign inst_data_ok = w_pop & (w_head_tag == TAG_INST);
  assign data_data_ok = w_pop & (w_head_tag == TAG_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_req && !mem_addr_ok) begin
            r_state <= w_sel_data ? ST_HOLD_DATA : ST_HOLD_INST;
          end
        end
        ST_HOLD_INST: begin
          if (w_hs || !inst_req) r_state <= ST_IDLE;
        end
        ST_HOLD_DATA: begin
          if (w_hs || !data_req) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  tag_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_hs),
    .i_din   (w_sel_data),
    .i_pop   (mem_data_ok),
    .o_dout  (w_head_tag),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with hand-computed expectations.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int unsigned n_cmp;
  int unsigned n_err;

  mem_req_arbiter #(.OUTSTANDING(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  function automatic logic [31:0] fifo_count();
    return 32'(dut.u_tag_fifo.r_count);
  endfunction

  function automatic logic [31:0] fsm_state();
    return 32'(dut.r_state);
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_inputs();
    resetn = 0;
    step();
    step();
    chk("rst_count", fifo_count(), 0);
    chk("rst_state", fsm_state(), 32'(ST_IDLE));
    resetn = 1;
    step();
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 0);
    chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 0);

    // Simultaneous requests: data side wins.
    inst_req = 1; inst_addr = 32'h0000_1000;
    data_req = 1; data_addr = 32'h0000_2000; data_wr = 1; data_size = 2'd1; data_wdata = 32'hDEAD_BEEF;
    mem_addr_ok = 1;
    #1;
    chk("prio_data_addr_ok", 32'(data_addr_ok), 1);
    chk("prio_inst_addr_ok", 32'(inst_addr_ok), 0);
    chk("prio_mem_addr", mem_addr, 32'h0000_2000);
    chk("prio_mem_wr", 32'(mem_wr), 1);
    chk("prio_mem_size", 32'(mem_size), 1);
    chk("prio_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    clear_inputs();
    chk("prio_count", fifo_count(), 1);
    mem_data_ok = 1; mem_rdata = 32'h0000_00AA;
    #1;
    chk("prio_data_data_ok", 32'(data_data_ok), 1);
    chk("prio_inst_data_ok", 32'(inst_data_ok), 0);
    chk("prio_data_rdata", data_rdata, 32'h0000_00AA);
    step();
    clear_inputs();
    chk("prio_drained", fifo_count(), 0);

    // Held instruction grant survives a rising data request.
    inst_req = 1; inst_addr = 32'h0000_0100;
    #1;
    chk("hold_c1_addr", mem_addr, 32'h0000_0100);
    chk("hold_c1_req", 32'(mem_req), 1);
    step();
    chk("hold_state", fsm_state(), 32'(ST_HOLD_INST));
    data_req = 1; data_addr = 32'h0000_0200;
    #1;
    chk("hold_c2_addr", mem_addr, 32'h0000_0100);
    chk("hold_c2_data_addr_ok", 32'(data_addr_ok), 0);
    step();
    #1;
    chk("hold_c3_addr", mem_addr, 32'h0000_0100);
    step();
    mem_addr_ok = 1;
    #1;
    chk("hold_c4_inst_addr_ok", 32'(inst_addr_ok), 1);
    chk("hold_c4_data_addr_ok", 32'(data_addr_ok), 0);
    chk("hold_c4_addr", mem_addr, 32'h0000_0100);
    step();
    chk("hold_c5_state", fsm_state(), 32'(ST_IDLE));
    #1;
    chk("hold_c5_data_addr_ok", 32'(data_addr_ok), 1);
    chk("hold_c5_addr", mem_addr, 32'h0000_0200);
    step();
    clear_inputs();
    chk("hold_count", fifo_count(), 2);
    mem_data_ok = 1; mem_rdata = 32'h0000_0001;
    #1;
    chk("hold_ret1_inst", 32'(inst_data_ok), 1);
    step();
    #1;
    chk("hold_ret2_data", 32'(data_data_ok), 1);
    step();
    clear_inputs();
    chk("hold_drained", fifo_count(), 0);

    // Held data grant released when the request drops.
    data_req = 1; data_addr = 32'h0000_0300;
    step();
    chk("drop_state_hold", fsm_state(), 32'(ST_HOLD_DATA));
    data_req = 0;
    step();
    chk("drop_state_idle", fsm_state(), 32'(ST_IDLE));
    chk("drop_count", fifo_count(), 0);

    // Fill with I,D,I,D, observe back-pressure, then drain in order.
    mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      inst_req = (i % 2 == 0);
      data_req = (i % 2 == 1);
      #1;
      chk("fill_inst_addr_ok", 32'(inst_addr_ok), 32'(i % 2 == 0));
      chk("fill_data_addr_ok", 32'(data_addr_ok), 32'(i % 2 == 1));
      step();
    end
    inst_req = 1; data_req = 0;
    #1;
    chk("full_count", fifo_count(), 4);
    chk("full_mem_req", 32'(mem_req), 0);
    chk("full_inst_addr_ok", 32'(inst_addr_ok), 0);
    step();
    clear_inputs();
    mem_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = 32'(8'h11 * (i + 1));
      #1;
      chk("drain_inst_data_ok", 32'(inst_data_ok), 32'(i % 2 == 0));
      chk("drain_data_data_ok", 32'(data_data_ok), 32'(i % 2 == 1));
      chk("drain_rdata", (i % 2 == 0) ? inst_rdata : data_rdata, 32'(8'h11 * (i + 1)));
      step();
    end
    clear_inputs();
    chk("drain_count", fifo_count(), 0);

    // Full FIFO: a pop in the same cycle does not let the new request through.
    mem_addr_ok = 1; inst_req = 1;
    repeat (4) step();
    mem_data_ok = 1; mem_rdata = 32'h0000_0055;
    #1;
    chk("fullpop_mem_req", 32'(mem_req), 0);
    chk("fullpop_inst_data_ok", 32'(inst_data_ok), 1);
    step();
    mem_data_ok = 0;
    chk("fullpop_count3", fifo_count(), 3);
    #1;
    chk("fullpop_next_addr_ok", 32'(inst_addr_ok), 1);
    step();
    clear_inputs();
    chk("fullpop_count4", fifo_count(), 4);
    mem_data_ok = 1;
    repeat (4) step();
    clear_inputs();
    chk("fullpop_drained", fifo_count(), 0);

    // Stray data_ok while empty.
    mem_data_ok = 1;
    #1;
    chk("empty_data_ok", {30'd0, inst_data_ok, data_data_ok}, 0);
    step();
    clear_inputs();
    chk("empty_count", fifo_count(), 0);

    // Reset with two outstanding requests.
    mem_addr_ok = 1; inst_req = 1;
    step();
    inst_req = 0; data_req = 1;
    step();
    clear_inputs();
    chk("midrst_count_before", fifo_count(), 2);
    data_req = 1;
    step();
    chk("midrst_state_hold", fsm_state(), 32'(ST_HOLD_DATA));
    #1;
    resetn = 0;
    #1;
    chk("midrst_count", fifo_count(), 0);
    chk("midrst_state", fsm_state(), 32'(ST_IDLE));
    clear_inputs();
    step();
    resetn = 1;
    mem_data_ok = 1;
    #1;
    chk("midrst_stray_data_ok", {30'd0, inst_data_ok, data_data_ok}, 0);
    step();
    clear_inputs();
    chk("midrst_count_after", fifo_count(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
